// File: rtl/serdes_pkg.sv
// Shared SerDes receive-path types and 8b/10b comma constants.
// Used by sipo_comma_aligner and comma_detect.
package serdes_pkg;

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} align_state_t;

   localparam logic [9:0] K28_5_RDN = 10'h17C;
   localparam logic [9:0] K28_5_RDP = 10'h283;

   function automatic int maxOf(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sipo_comma_aligner_comma_detect.sv
// Combinational comma compare: matches the window against COMMA or its complement,
// so both running disparities of K28.5 are recognised.
module comma_detect
   import serdes_pkg::*;
#(
   parameter int               WIDTH = 10,
   parameter logic [WIDTH-1:0] COMMA = WIDTH'(K28_5_RDN)
) (
   input  logic [WIDTH-1:0] window,
   output logic             match
);

   assign match = (window == COMMA) || (window == ~COMMA);

endmodule

// File: rtl/sipo_comma_aligner.sv
// Single-clock SIPO with K28.5 comma alignment and a hunt/verify/locked FSM.
// Optional `define SIPO_COMMA_CNT_EN adds a saturating Comma_Count output.
module sipo_comma_aligner
   import serdes_pkg::*;
#(
   parameter int               WIDTH      = 10,
   parameter logic [WIDTH-1:0] COMMA      = WIDTH'(K28_5_RDN),
   parameter int               LOCK_COUNT = 3,
   parameter int               LOSS_COUNT = 4
) (
   input  logic             BitCLK,
   input  logic             Reset,
   input  logic             Serial,
   input  logic             Align_En,
   output logic [WIDTH-1:0] RxParallel,
   output logic             RxValid,
   output logic             Comma_Det,
   output logic             Locked,
   output logic             Align_Error
`ifdef SIPO_COMMA_CNT_EN
   ,
   output logic [15:0]      Comma_Count
`endif
);

   localparam int CNT_W = $clog2(maxOf(LOCK_COUNT, LOSS_COUNT) + 1);
   localparam int BIT_W = $clog2(WIDTH);

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [BIT_W-1:0] bit_idx_t;

   localparam cnt_t     LOCK_TH  = cnt_t'(LOCK_COUNT);
   localparam cnt_t     LOSS_TH  = cnt_t'(LOSS_COUNT);
   localparam cnt_t     CNT_ONE  = cnt_t'(1);
   localparam bit_idx_t LAST_BIT = bit_idx_t'(WIDTH - 1);

   logic [WIDTH-1:0] window;
   logic [WIDTH-1:0] nextWindow;
   bit_idx_t         bitCnt;
   align_state_t     state;
   align_state_t     stateNext;
   cnt_t             goodCnt;
   cnt_t             goodCntNext;
   cnt_t             badCnt;
   cnt_t             badCntNext;
   logic             alignErrNext;

   logic match;
   logic natBoundary;
   logic alignedComma;
   logic misalignedComma;
   logic realign;
   logic boundary;

   // Oldest bit drifts down to bit 0, so COMMA is written first-received-bit-first.
   assign nextWindow = {Serial, window[WIDTH-1:1]};

   comma_detect #(
      .WIDTH (WIDTH),
      .COMMA (COMMA)
   ) u_comma_detect (
      .window (nextWindow),
      .match  (match)
   );

   assign natBoundary     = (bitCnt == LAST_BIT);
   assign alignedComma    = match && natBoundary;
   assign misalignedComma = match && !natBoundary;
   assign realign         = misalignedComma && Align_En && (state != LOCKED);
   assign boundary        = natBoundary || realign;

   // NOTE: every output of this block gets a default first, so no path leaves a
   // variable unassigned and no latch is inferred.
   always_comb begin
      stateNext    = state;
      goodCntNext  = goodCnt;
      badCntNext   = badCnt;
      alignErrNext = 1'b0;
      unique case (state)
         HUNT: begin
            if (realign || alignedComma) begin
               if (LOCK_COUNT == 1) begin
                  stateNext   = LOCKED;
                  goodCntNext = LOCK_TH;
                  badCntNext  = '0;
               end else begin
                  stateNext   = VERIFY;
                  goodCntNext = CNT_ONE;
               end
            end
         end
         VERIFY: begin
            if (realign) begin
               goodCntNext = CNT_ONE;
            end else if (alignedComma) begin
               if (goodCnt + CNT_ONE == LOCK_TH) begin
                  stateNext   = LOCKED;
                  goodCntNext = LOCK_TH;
                  badCntNext  = '0;
               end else begin
                  goodCntNext = goodCnt + CNT_ONE;
               end
            end
         end
         LOCKED: begin
            if (misalignedComma) begin
               if (badCnt + CNT_ONE == LOSS_TH) begin
                  stateNext    = HUNT;
                  goodCntNext  = '0;
                  badCntNext   = '0;
                  alignErrNext = 1'b1;
               end else begin
                  badCntNext = badCnt + CNT_ONE;
               end
            end else if (alignedComma) begin
               badCntNext = '0;
            end
         end
         default: stateNext = HUNT;
      endcase
   end

   // NOTE: non-blocking assignments throughout, so every register samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge BitCLK) begin
      if (Reset) begin
         window      <= '0;
         bitCnt      <= '0;
         state       <= HUNT;
         goodCnt     <= '0;
         badCnt      <= '0;
         RxParallel  <= '0;
         RxValid     <= 1'b0;
         Comma_Det   <= 1'b0;
         Align_Error <= 1'b0;
      end else begin
         window      <= nextWindow;
         bitCnt      <= boundary ? '0 : bitCnt + bit_idx_t'(1);
         state       <= stateNext;
         goodCnt     <= goodCntNext;
         badCnt      <= badCntNext;
         RxValid     <= boundary;
         Comma_Det   <= boundary && match;
         Align_Error <= alignErrNext;
         if (boundary) begin
            RxParallel <= nextWindow;
         end
      end
   end

   assign Locked = (state == LOCKED);

`ifdef SIPO_COMMA_CNT_EN
   // Only commas seen while already locked are counted; the locking comma is not.
   always_ff @(posedge BitCLK) begin
      if (Reset) begin
         Comma_Count <= '0;
      end else if ((stateNext == HUNT) && (state != HUNT)) begin
         Comma_Count <= '0;
      end else if ((state == LOCKED) && alignedComma && (Comma_Count != 16'hFFFF)) begin
         Comma_Count <= Comma_Count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sipo_comma_aligner.sv
// Directed bench for sipo_comma_aligner: table-driven lock sequence plus
// hand-written slip, hold-off, frozen-boundary and mid-word reset sequences.
module tb_sipo_comma_aligner;
   import serdes_pkg::*;

   logic       BitCLK = 1'b0;
   logic       Reset;
   logic       Serial;
   logic       Align_En;
   logic [9:0] RxParallel;
   logic       RxValid;
   logic       Comma_Det;
   logic       Locked;
   logic       Align_Error;
`ifdef SIPO_COMMA_CNT_EN
   logic [15:0] Comma_Count;
`endif

   sipo_comma_aligner dut (
      .BitCLK      (BitCLK),
      .Reset       (Reset),
      .Serial      (Serial),
      .Align_En    (Align_En),
      .RxParallel  (RxParallel),
      .RxValid     (RxValid),
      .Comma_Det   (Comma_Det),
      .Locked      (Locked),
      .Align_Error (Align_Error)
`ifdef SIPO_COMMA_CNT_EN
      ,
      .Comma_Count (Comma_Count)
`endif
   );

   always #5 BitCLK = ~BitCLK;

   typedef struct {
      logic [9:0] word;
      int         expStrobes;
      logic [9:0] expPar;
      logic       expCd;
      logic       expLocked;
      int         expAe;
      int         expCc;
   } vec_t;

   vec_t vecs[4];

   int         checks = 0;
   int         failures = 0;
   int         strobes;
   int         aeSeen;
   int         commaWords;
   logic [9:0] lastPar;
   logic       lastCd;
   logic       polarity = 1'b0;
   logic [9:0] sent;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic clearStats();
      strobes    = 0;
      aeSeen     = 0;
      commaWords = 0;
      lastPar    = '0;
      lastCd     = 1'b0;
   endtask

   // Drive n bits LSB first, one per rising edge, and log what the DUT emitted.
   task automatic sendBits(input logic [9:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge BitCLK);
         Serial = bits[i];
         @(posedge BitCLK);
         #1;
         if (RxValid) begin
            strobes++;
            lastPar = RxParallel;
            lastCd  = Comma_Det;
            if (RxParallel == K28_5_RDN || RxParallel == K28_5_RDP) commaWords++;
         end
         if (Align_Error) aeSeen++;
      end
   endtask

   task automatic sendWord(input logic [9:0] w);
      clearStats();
      sendBits(w, 10);
   endtask

   task automatic nextComma(output logic [9:0] w);
      w = polarity ? K28_5_RDP : K28_5_RDN;
      polarity = ~polarity;
   endtask

   task automatic sendComma();
      nextComma(sent);
      sendWord(sent);
   endtask

   task automatic doReset(input string tag);
      Reset  = 1'b1;
      Serial = 1'b0;
      repeat (2) @(posedge BitCLK);
      #1;
      check({tag, "_rst_par"}, RxParallel, 0);
      check({tag, "_rst_valid"}, RxValid, 0);
      check({tag, "_rst_cd"}, Comma_Det, 0);
      check({tag, "_rst_locked"}, Locked, 0);
      check({tag, "_rst_ae"}, Align_Error, 0);
`ifdef SIPO_COMMA_CNT_EN
      check({tag, "_rst_cc"}, Comma_Count, 0);
`endif
      Reset = 1'b0;
      polarity = 1'b0;
   endtask

   initial begin
      Reset    = 1'b1;
      Serial   = 1'b0;
      Align_En = 1'b1;

      // Idle zeros: strobe exactly every 10th bit carrying zero.
      doReset("idle");
      clearStats();
      sendBits(10'h000, 9);
      check("idle_no_early_strobe", strobes, 0);
      sendBits(10'h000, 1);
      check("idle_first_strobe", strobes, 1);
      check("idle_par", lastPar, 10'h000);
      check("idle_cd", lastCd, 0);
      check("idle_locked", Locked, 0);
      clearStats();
      sendBits(10'h000, 10);
      check("idle_period", strobes, 1);

      // Three junk bits then alternating K28.5; the first comma realigns the
      // boundary, the next two aligned commas complete lock.
      vecs[0] = '{10'h17C, 2, 10'h17C, 1'b1, 1'b0, 0, 0};
      vecs[1] = '{10'h283, 1, 10'h283, 1'b1, 1'b0, 0, 0};
      vecs[2] = '{10'h17C, 1, 10'h17C, 1'b1, 1'b1, 0, 0};
      vecs[3] = '{10'h283, 1, 10'h283, 1'b1, 1'b1, 0, 1};
      doReset("lock");
      clearStats();
      sendBits(10'b101, 3);
      for (int r = 0; r < 4; r++) begin
         sendWord(vecs[r].word);
         check($sformatf("row%0d_strobes", r), strobes, vecs[r].expStrobes);
         check($sformatf("row%0d_par", r), lastPar, vecs[r].expPar);
         check($sformatf("row%0d_cd", r), lastCd, vecs[r].expCd);
         check($sformatf("row%0d_locked", r), Locked, vecs[r].expLocked);
         check($sformatf("row%0d_ae", r), aeSeen, vecs[r].expAe);
`ifdef SIPO_COMMA_CNT_EN
         check($sformatf("row%0d_cc", r), Comma_Count, vecs[r].expCc);
`endif
      end
      polarity = 1'b0;

      // One-bit slip: four misaligned commas drop lock with one error pulse,
      // then realign + two aligned commas relock.
      clearStats();
      sendBits(10'h000, 1);
      for (int k = 0; k < 4; k++) begin
         sendComma();
         check($sformatf("slip%0d_locked", k), Locked, (k < 3) ? 1 : 0);
         check($sformatf("slip%0d_ae", k), aeSeen, (k < 3) ? 0 : 1);
      end
`ifdef SIPO_COMMA_CNT_EN
      check("slip_cc_cleared", Comma_Count, 0);
`endif
      sendComma();
      check("relock_realign_par", lastPar, sent);
      check("relock_realign_cd", lastCd, 1);
      check("relock_realign_locked", Locked, 0);
      check("relock_no_second_ae", aeSeen, 0);
      sendComma();
      check("relock_verify_locked", Locked, 0);
      sendComma();
      check("relock_locked", Locked, 1);

      // Three misaligned then one aligned comma: bad count clears, lock holds.
      clearStats();
      sendBits(10'h000, 1);
      for (int k = 0; k < 3; k++) begin
         sendComma();
         check($sformatf("hold%0d_locked", k), Locked, 1);
         check($sformatf("hold%0d_ae", k), aeSeen, 0);
      end
      clearStats();
      sendBits(10'h000, 9);
      sendComma();
      check("hold_aligned_locked", Locked, 1);
      check("hold_aligned_ae", aeSeen, 0);
      clearStats();
      sendBits(10'h000, 1);
      sendComma();
      check("hold_badcnt_reset_locked", Locked, 1);
      check("hold_badcnt_reset_ae", aeSeen, 0);
      clearStats();
      sendBits(10'h000, 9);
      sendComma();

      // Frozen boundary: comma at offset 5 is never emitted and no lock forms.
      Align_En = 1'b0;
      doReset("frozen");
      clearStats();
      sendBits(10'h000, 5);
      for (int k = 0; k < 6; k++) begin
         nextComma(sent);
         sendBits(sent, 10);
      end
      check("frozen_comma_words", commaWords, 0);
      check("frozen_locked", Locked, 0);
      Align_En = 1'b1;
      sendComma();
      check("unfreeze_par", lastPar, sent);
      check("unfreeze_cd", lastCd, 1);
      sendComma();
      check("unfreeze_verify_locked", Locked, 0);
      sendComma();
      check("unfreeze_locked", Locked, 1);

      // Reset mid-word: outputs clear on the next edge and the partial word is lost.
      nextComma(sent);
      sendBits(sent, 4);
      @(negedge BitCLK);
      Reset = 1'b1;
      @(posedge BitCLK);
      #1;
      check("midrst_par", RxParallel, 0);
      check("midrst_valid", RxValid, 0);
      check("midrst_cd", Comma_Det, 0);
      check("midrst_locked", Locked, 0);
      check("midrst_ae", Align_Error, 0);
`ifdef SIPO_COMMA_CNT_EN
      check("midrst_cc", Comma_Count, 0);
`endif
      Reset = 1'b0;
      clearStats();
      sendBits(10'h000, 9);
      check("midrst_no_partial", strobes, 0);
      sendBits(10'h000, 1);
      check("midrst_first_strobe", strobes, 1);
      check("midrst_first_par", lastPar, 10'h000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
